wb_queue_axi: RTL

WB_QUEUE_AXI -- requirements
Module: wb_queue_axi

---
 rtl/wb_queue_axi.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_queue_axi.sv
// ---------------------------------------------------------------------------
// wb_queue_axi
//
// Write-back queue sitting between a cache and an AXI write channel. Dirty
// lines (cached) and single-word stores (uncached) are pushed into a small
// circular FIFO and drained one at a time as AXI write bursts. An entry stays
// in the FIFO, and stays visible to the probe port, until its write response
// has been accepted. This lets the cache detect reads of lines that are
// still in flight.
//
// Parameters
//   DEPTH       number of queue entries (power of two, 2..16)
//   LINE_WORDS  32-bit words per cache line (power of two, 1..64)
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   push, push_ready    enqueue handshake
//   push_addr           line address (cached) or byte address (uncached)
//   push_uncache        1 = single-word store, 0 = full-line write-back
//   push_strb           byte enables for uncached stores
//   push_line           line data, word 0 in bits [31:0]
//   aw*/w*/b*           AXI write address, data and response channels
//   probe_addr/hit      line-granular match against all pending entries
//   empty               nothing queued and the drain engine is idle
//   count               number of valid entries
// ---------------------------------------------------------------------------
module wb_queue_axi #(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = 16
) (
    input  logic                      clk,
    input  logic                      rstn,

    input  logic                      push,
    output logic                      push_ready,
    input  logic [31:0]               push_addr,
    input  logic                      push_uncache,
    input  logic [3:0]                push_strb,
    input  logic [32*LINE_WORDS-1:0]  push_line,

    output logic                      awvalid,
    input  logic                      awready,
    output logic [31:0]               awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,

    output logic                      wvalid,
    input  logic                      wready,
    output logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic                      wlast,

    input  logic                      bvalid,
    output logic                      bready,

    input  logic [31:0]               probe_addr,
    output logic                      probe_hit,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int          PTR_W     = $clog2(DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam int          BEAT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);
    localparam logic [7:0]  LINE_LEN  = 8'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2,
        S_B    = 2'd3
    } state_t;

    // Entry storage; contents are written once on push and never touched again
    logic [31:0]              addr_mem [DEPTH];
    logic                     unc_mem  [DEPTH];
    logic [3:0]               strb_mem [DEPTH];
    logic [32*LINE_WORDS-1:0] line_mem [DEPTH];

    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [BEAT_W-1:0] beat_q;

    state_t state_q;
    state_t state_d;

    logic awvalid_q;
    logic wvalid_q;
    logic bready_q;

    logic push_fire;
    logic retire;
    logic last_beat;

    logic [31:0] head_addr;
    logic        head_unc;
    logic [3:0]  head_strb;
    logic [7:0]  head_len;

    // Advance a queue pointer, wrapping from the last slot back to slot 0
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // The head entry retires on the B handshake. A retire frees a slot in
    // that same cycle, so a full queue can still accept a push alongside it.
    assign retire     = bready_q & bvalid;
    assign push_ready = (count_q != CNT_W'(DEPTH)) | retire;
    assign push_fire  = push & push_ready;

    // Fields of the entry currently being drained
    assign head_addr = addr_mem[rd_ptr];
    assign head_unc  = unc_mem[rd_ptr];
    assign head_strb = strb_mem[rd_ptr];
    assign head_len  = head_unc ? 8'd0 : LINE_LEN;

    // Cached lines are written as an aligned incrementing burst of full
    // words; uncached stores go out as one beat at the original byte address
    // so the slave sees the exact address the CPU issued.
    assign awvalid = awvalid_q;
    assign awaddr  = head_unc ? head_addr : (head_addr & ~LINE_MASK);
    assign awlen   = head_len;
    assign awsize  = 3'd2;

    // The beat counter picks the word from the stored line; for an uncached
    // entry it never leaves zero, so word 0 is the store data.
    assign last_beat = (8'(beat_q) == head_len);
    assign wvalid    = wvalid_q;
    assign wdata     = line_mem[rd_ptr][32*beat_q +: 32];
    assign wstrb     = head_unc ? head_strb : 4'hF;
    assign wlast     = wvalid_q & last_beat;

    assign bready = bready_q;
    assign count  = count_q;
    assign empty  = (count_q == '0) && (state_q == S_IDLE);

    // Probe compares every valid entry at line granularity. Uncached entries
    // use the same granularity so a store to any byte of a line is caught.
    // Valid bits are registered, so an entry pushed this cycle is not seen yet.
    always_comb begin
        probe_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (((addr_mem[i] ^ probe_addr) & ~LINE_MASK) == 32'd0)) begin
                probe_hit = 1'b1;
            end
        end
    end

    // Drain sequencing: wait for work, send the address, stream the beats,
    // then wait for the response before touching the next entry. Only one
    // transaction is ever outstanding and entries leave in push order.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_AW;
                end
            end
            S_AW: begin
                if (awvalid_q && awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (wvalid_q && wready && last_beat) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                if (bready_q && bvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register plus the channel valid/ready flops. The flops are
    // loaded from the next state so they line up exactly with the state they
    // belong to, and reset clears them immediately, abandoning any burst.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= (state_d == S_AW);
            wvalid_q  <= (state_d == S_W);
            bready_q  <= (state_d == S_B);
        end
    end

    // Beat counter for the W channel. It moves only on an accepted beat and
    // returns to zero after the last one, ready for the next burst.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_q <= '0;
        end else if ((state_q == S_W) && wvalid_q && wready) begin
            if (last_beat) begin
                beat_q <= '0;
            end else begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

    // Queue bookkeeping. Full and empty are told apart by the count rather
    // than pointer equality. When a retire and a push hit the same slot (full
    // queue), the push is applied last so the new entry is left valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (retire) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= next_ptr(rd_ptr);
            end
            if (push_fire) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            case ({push_fire, retire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload. This is plain storage with no reset; the valid bits
    // decide whether a slot means anything.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            addr_mem[wr_ptr] <= push_addr;
            unc_mem[wr_ptr]  <= push_uncache;
            strb_mem[wr_ptr] <= push_strb;
            line_mem[wr_ptr] <= push_line;
        end
    end

endmodule
